// File: rtl/dw_conv_seq.sv
// ============================================================================
// Module      : dw_conv_seq
// Description : Depthwise convolution engine. A coefficient store is loaded per
//               channel in CFG, then LANES channels per beat are convolved
//               through a two-stage stallable pipeline with ReLU, shift and clip.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dw_conv_seq #(
    parameter int CH    = 32,
    parameter int LANES = 8,
    parameter int K     = 9,
    parameter int AW    = 8,
    parameter int WW    = 2,
    parameter int BW    = 8,
    parameter int SHIFT = 1,
    parameter int CLIP  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(CH)-1:0]     cfg_addr,
    input  logic [K*WW+BW-1:0]        cfg_wdata,
    input  logic                      cfg_done,
    input  logic                      cfg_start,
    input  logic                      clip_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*K*AW-1:0]     in_act,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*AW-1:0]       out_act,
    output logic                      out_last,
    output logic [1:0]                state_o
);

    localparam int c_cw  = K * WW + BW;
    localparam int c_ng  = CH / LANES;
    localparam int c_gw  = (c_ng > 1) ? $clog2(c_ng) : 1;
    localparam int c_aiw = $clog2(CH);

    localparam logic [1:0] c_st_cfg   = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic signed [31:0] c_clip = 32'(CLIP);
    localparam logic signed [31:0] c_sat  = 32'((2 ** (AW - 1)) - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [c_gw-1:0]       r_grp;
    logic [c_cw-1:0]       r_coef [CH];

    logic                  r_s1_v;
    logic                  r_s1_last;
    logic                  r_s1_clip;
    logic [LANES*K*AW-1:0] r_s1_act;
    logic [c_cw-1:0]       r_s1_coef [LANES];

    logic                  w_stall;
    logic                  w_s1_load;
    logic                  w_accept;
    logic [c_cw-1:0]       w_sel [LANES];
    logic [LANES*AW-1:0]   w_res;

    assign w_stall   = out_valid && !out_ready;
    // Stage 1 may refill whenever it is empty, even while stage 2 is stalled.
    assign w_s1_load = !r_s1_v || !w_stall;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_cfg;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_cfg:   if (cfg_done)  w_next = c_st_run;
            c_st_run:   if (cfg_start) w_next = c_st_drain;
            c_st_drain: if (!r_s1_v && !out_valid) w_next = c_st_cfg;
            default:    w_next = c_st_cfg;
        endcase
    end

    always_comb begin
        in_ready = (r_state == c_st_run) && w_s1_load;
        state_o  = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp <= '0;
        end else if (r_state == c_st_cfg && cfg_done) begin
            r_grp <= '0;
        end else if (w_accept) begin
            r_grp <= (r_grp == c_gw'(c_ng - 1)) ? '0 : r_grp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) r_coef[i] <= '0;
        end else if (r_state == c_st_cfg && cfg_we) begin
            r_coef[cfg_addr] <= cfg_wdata;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_sel
        logic [c_aiw-1:0] w_idx;
        assign w_idx    = c_aiw'(r_grp) * c_aiw'(LANES) + c_aiw'(l);
        assign w_sel[l] = r_coef[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_clip <= 1'b0;
            r_s1_act  <= '0;
            for (int l = 0; l < LANES; l++) r_s1_coef[l] <= '0;
        end else if (w_s1_load) begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_act  <= in_act;
                r_s1_last <= (r_grp == c_gw'(c_ng - 1));
                r_s1_clip <= clip_en;
                for (int l = 0; l < LANES; l++) r_s1_coef[l] <= w_sel[l];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [31:0] w_acc;
        logic signed [31:0] w_shr;
        logic signed [31:0] w_lim;
        logic [AW-1:0]      w_lane;

        always_comb begin
            w_acc = 32'($signed(r_s1_coef[l][K*WW +: BW]));
            for (int t = 0; t < K; t++) begin
                w_acc = w_acc + 32'($signed(r_s1_act[(l*K+t)*AW +: AW]))
                              * 32'($signed(r_s1_coef[l][t*WW +: WW]));
            end
            w_shr = w_acc >>> SHIFT;
            w_lim = r_s1_clip ? c_clip : c_sat;
            if (w_acc < 0) begin
                w_lane = '0;
            end else if (w_shr > w_lim) begin
                w_lane = w_lim[AW-1:0];
            end else begin
                w_lane = w_shr[AW-1:0];
            end
        end

        assign w_res[l*AW +: AW] = w_lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_act   <= '0;
            out_last  <= 1'b0;
        end else if (!w_stall) begin
            out_valid <= r_s1_v;
            if (r_s1_v) begin
                out_act  <= w_res;
                out_last <= r_s1_last;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dw_conv_seq.sv
// ============================================================================
// Module      : tb_dw_conv_seq
// Description : Directed and randomized bench for dw_conv_seq with a queue-based
//               reference model of the per-channel convolution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dw_conv_seq;

    localparam int CH    = 32;
    localparam int LANES = 8;
    localparam int K     = 9;
    localparam int AW    = 8;
    localparam int WW    = 2;
    localparam int BW    = 8;
    localparam int SHIFT = 1;
    localparam int CLIP  = 6;
    localparam int NG    = CH / LANES;
    localparam int AIW   = $clog2(CH);
    localparam int CW    = K * WW + BW;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_we = 1'b0;
    logic [AIW-1:0]        cfg_addr = '0;
    logic [CW-1:0]         cfg_wdata = '0;
    logic                  cfg_done = 1'b0;
    logic                  cfg_start = 1'b0;
    logic                  clip_en = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*K*AW-1:0] in_act = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [LANES*AW-1:0]   out_act;
    logic                  out_last;
    logic [1:0]            state_o;

    dw_conv_seq #(
        .CH(CH), .LANES(LANES), .K(K), .AW(AW), .WW(WW),
        .BW(BW), .SHIFT(SHIFT), .CLIP(CLIP)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_done(cfg_done), .cfg_start(cfg_start),
        .clip_en(clip_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .out_valid(out_valid), .out_ready(out_ready),
        .out_act(out_act), .out_last(out_last), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int wt [CH][K];
    int bs [CH];
    int gm = 0;
    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int n_last = 0;
    bit last_acc = 1'b0;
    logic [LANES*AW:0] expq [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_lane(int ch, logic [K*AW-1:0] a, bit clip);
        int acc, s, lim;
        acc = bs[ch];
        for (int t = 0; t < K; t++) acc += int'($signed(a[t*AW +: AW])) * wt[ch][t];
        if (acc < 0) return '0;
        s   = acc / (2 ** SHIFT);
        lim = clip ? CLIP : (2 ** (AW - 1)) - 1;
        if (s > lim) s = lim;
        return AW'(s);
    endfunction

    function automatic logic [LANES*AW:0] ref_beat(int grp, logic [LANES*K*AW-1:0] a, bit clip);
        logic [LANES*AW:0] r;
        r[LANES*AW] = (grp == NG - 1);
        for (int l = 0; l < LANES; l++)
            r[l*AW +: AW] = ref_lane(grp * LANES + l, a[l*K*AW +: K*AW], clip);
        return r;
    endfunction

    function automatic logic [LANES*AW-1:0] fill(int v);
        logic [LANES*AW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*AW +: AW] = AW'(v);
        return r;
    endfunction

    function automatic logic [LANES*K*AW-1:0] act_fill(int v);
        logic [LANES*K*AW-1:0] r;
        for (int i = 0; i < LANES * K; i++) r[i*AW +: AW] = AW'(v);
        return r;
    endfunction

    function automatic logic [LANES*K*AW-1:0] act_rand();
        logic [LANES*K*AW-1:0] r;
        for (int i = 0; i < LANES * K; i++) r[i*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    // One clock: observe handshakes mid-cycle, update scoreboard, return just after the edge.
    task automatic tick();
        logic [LANES*AW:0] e;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst) begin
            expq.delete();
            gm = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (out_last) n_last++;
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL spurious_out observed=%0h expected=none", {out_last, out_act});
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 128'({out_last, out_act}), 128'(e));
                end
            end
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                expq.push_back(ref_beat(gm, in_act, clip_en));
                gm = (gm + 1) % NG;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch);
        logic [CW-1:0] wd;
        for (int t = 0; t < K; t++) wd[t*WW +: WW] = WW'(wt[ch][t]);
        wd[K*WW +: BW] = BW'(bs[ch]);
        cfg_we    = 1'b1;
        cfg_addr  = AIW'(ch);
        cfg_wdata = wd;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic load(input int mode);
        for (int ch = 0; ch < CH; ch++) begin
            for (int t = 0; t < K; t++)
                wt[ch][t] = (mode == 0) ? 1 : (mode == 1) ? -1 : int'($urandom_range(3)) - 2;
            bs[ch] = (mode == 2) ? int'($urandom_range(255)) - 128 : 0;
            wr(ch);
        end
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        gm = 0;
        chk("enter_run", 128'(state_o), 128'(1));
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        for (int i = 0; i < 30 && state_o !== s; i++) tick();
        chk(tag, 128'(state_o), 128'(s));
    endtask

    task automatic directed(input logic [LANES*K*AW-1:0] a, input bit clip,
                            input logic [LANES*AW-1:0] expv, input string tag);
        in_valid = 1'b1;
        in_act   = a;
        clip_en  = clip;
        tick();
        in_valid = 1'b0;
        chk({tag, "_accept"}, 128'(last_acc), 128'(1));
        chk({tag, "_lat1"}, 128'(out_valid), 128'(0));
        tick();
        chk({tag, "_lat2"}, 128'(out_valid), 128'(1));
        chk(tag, 128'(out_act), 128'(expv));
        tick();
    endtask

    initial begin
        int n0, l0;
        logic [LANES*AW-1:0] snap;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_state", 128'(state_o), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_act", 128'(out_act), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("cfg_start_in_cfg", 128'(state_o), 128'(0));

        load(0);
        // Writes in RUN must not touch the store; channel 0 is used by the next beat.
        cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = '1;
        tick();
        cfg_we = 1'b0;
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        chk("cfg_done_in_run", 128'(state_o), 128'(1));

        directed(act_fill(1), 1'b1, fill(4), "ones");
        directed(act_fill(2), 1'b1, fill(6), "twos_clip");
        directed(act_fill(2), 1'b0, fill(9), "twos_noclip");

        n0 = n_out;
        in_valid = 1'b1; in_act = act_rand(); clip_en = 1'b0;
        tick();
        in_act = act_rand(); cfg_start = 1'b1;
        tick();
        in_valid = 1'b0; cfg_start = 1'b0;
        chk("drain_state", 128'(state_o), 128'(2));
        chk("drain_in_ready", 128'(in_ready), 128'(0));
        wait_state(2'd0, "drain_to_cfg");
        chk("drain_outs", 128'(n_out - n0), 128'(2));

        load(1);
        directed(act_fill(5), 1'b1, fill(0), "neg_relu");
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_state(2'd0, "back_to_cfg");

        load(2);
        n0 = n_out; l0 = n_last;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_act = act_rand(); clip_en = 1'($urandom);
            tick();
            chk("b2b_accept", 128'(last_acc), 128'(1));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_outs", 128'(n_out - n0), 128'(5));
        chk("b2b_last_count", 128'(n_last - l0), 128'(1));

        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom);
            in_act    = act_rand();
            clip_en   = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rand_q_empty", 128'(expq.size()), 128'(0));

        out_ready = 1'b0;
        in_valid = 1'b1; in_act = act_rand(); clip_en = 1'b0;
        tick();
        in_act = act_rand();
        tick();
        chk("stall_in_ready", 128'(in_ready), 128'(0));
        snap = out_act;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_hold", 128'(out_act), 128'(snap));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_q_empty", 128'(expq.size()), 128'(0));

        in_valid = 1'b1; in_act = act_rand();
        tick();
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_state", 128'(state_o), 128'(0));
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_quiet", 128'(out_valid), 128'(0));
        end
        in_valid = 1'b0;
        chk("final_q_empty", 128'(expq.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/dw_conv_seq.md
DW_CONV_SEQ -- requirements
Module: dw_conv_seq

Interface
REQ-001 SHALL have parameter CH, default 32, total depthwise channels.
REQ-002 SHALL have parameter LANES, default 8, channels per beat; CH divisible by LANES.
REQ-003 SHALL have parameter K, default 9, kernel taps per channel.
REQ-004 SHALL have parameter AW, default 8, signed activation width.
REQ-005 SHALL have parameter WW, default 2, signed weight width.
REQ-006 SHALL have parameter BW, default 8, signed bias width.
REQ-007 SHALL have parameter SHIFT, default 1, output right-shift.
REQ-008 SHALL have parameter CLIP, default 6, clip ceiling when clip_en=1.
REQ-009 SHALL have ports: clk input 1 clock; rst input 1 reset; cfg_we input 1 weight write strobe; cfg_addr input clog2(CH) channel index; cfg_wdata input K*WW+BW {bias, tap K-1..tap 0}; cfg_done input 1 config complete; cfg_start input 1 request reconfig; clip_en input 1 clip mode; in_valid input 1; in_ready output 1; in_act input LANES*K*AW, lane l tap t at bits [(l*K+t)*AW +: AW]; out_valid output 1; out_ready input 1; out_act output LANES*AW; out_last output 1 last group of frame; state_o output 2 current state.
REQ-010 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-011 SHALL implement states CFG(0), RUN(1), DRAIN(2); state_o reflects state.
REQ-012 CFG: cfg_we writes cfg_wdata into channel cfg_addr coefficient store; in_ready=0; cfg_done moves to RUN next cycle.
REQ-013 RUN: cfg_we ignored; cfg_start moves to DRAIN; in_ready = pipeline can advance (stage 1 empty or pipeline not stalled).
REQ-014 DRAIN: in_ready=0; moves to CFG the cycle after both pipeline stages empty and out_valid=0.
REQ-015 Input accepted when in_valid&&in_ready; group counter g (0..CH/LANES-1) increments per accepted beat, wraps to 0 after CH/LANES-1, reset to 0 on entering RUN.
REQ-016 Beat for group g lane l SHALL use weights/bias of channel g*LANES+l.
REQ-017 Pipeline: stage 1 registers activations, weights, bias, last flag; stage 2 computes and registers out_act; latency 2 cycles from acceptance to out_valid with no stall.
REQ-018 Stall: when out_valid=1 and out_ready=0 all stages hold; out_act and out_last stable until out_ready.
REQ-019 Arithmetic: acc = sum over taps of signed(act)*signed(weight) plus sign-extended bias, 32-bit signed, no overflow handling needed.
REQ-020 Activation: acc<0 -> 0; else s = acc>>SHIFT; clip_en=1 -> min(s, CLIP); clip_en=0 -> min(s, 2^(AW-1)-1).
REQ-021 clip_en sampled at stage 1 with the beat.
REQ-022 out_last=1 with the output of group CH/LANES-1.
REQ-023 cfg_done and cfg_start outside their states SHALL be ignored; simultaneous cfg_start and input acceptance in RUN: beat accepted, then DRAIN.

Reset
REQ-024 On rst: state CFG, g=0, pipeline valids 0, out_valid=0, out_act=0, out_last=0, in_ready=0; coefficient store cleared to 0.
REQ-025 rst mid-operation SHALL discard in-flight beats; no output after rst deasserts until reconfigured and new input.

Verification
REQ-026 Load all weights 1, bias 0, clip_en=1; beat with all acts 1 -> each lane 9>>1=4, out_valid 2 cycles after accept.
REQ-027 Same config, acts 2 -> 18>>1=9 clipped to 6; clip_en=0 -> 9.
REQ-028 Weights -1, acts 5 -> acc -45 -> output 0 all lanes.
REQ-029 CH=32, LANES=8: 4 back-to-back beats -> out_last only on 4th; 5th beat uses channels 0..7.
REQ-030 out_ready held low 3 cycles with full pipeline -> in_ready=0, out_act stable, no beat lost or duplicated.
REQ-031 cfg_start with 2 beats in flight -> state DRAIN, both outputs delivered, then CFG; rst asserted mid-RUN -> out_valid=0 next cycle.
